// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready handshakes and kill
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            state_q;
  logic [2:0]        op_q;
  logic              sgn_q;
  logic [XLEN-1:0]   opb_q, res_q;
  logic [2*XLEN-1:0] prod_q, prod_d, prod_n;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_div, a_sgd, b_sgd, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0]   mag_a, mag_b, sp_res, div_val, fin;
  logic [XLEN:0]     msum, hi, diff;
  assign in_ready   = (state_q == IDLE) & ~reset;
  assign out_valid  = state_q == DONE;
  assign out_result = res_q;
  always_comb begin
    is_div  = in_funct3[2];
    a_sgd   = is_div ? ~in_funct3[0] : (in_funct3[1:0] != 2'b11);
    b_sgd   = is_div ? ~in_funct3[0] : ~in_funct3[1];
    a_neg   = a_sgd & in_a[XLEN-1];
    b_neg   = b_sgd & in_b[XLEN-1];
    mag_a   = a_neg ? -in_a : in_a;
    mag_b   = b_neg ? -in_b : in_b;
    b_zero  = in_b == '0;
    ovf     = is_div & ~in_funct3[0] & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (&in_b);
    sp_res  = b_zero ? (in_funct3[1] ? in_a : '1) : (in_funct3[1] ? '0 : in_a);
    // multiply: add multiplicand into upper half then shift right; divide: {rem, quo} shifts left
    msum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    hi      = prod_q[2*XLEN-1:XLEN-1];
    diff    = hi - {1'b0, opb_q};
    prod_d  = ~op_q[2] ? {msum, prod_q[XLEN-1:1]} :
              diff[XLEN] ? {hi[XLEN-1:0], prod_q[XLEN-2:0], 1'b0} :
                           {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    prod_n  = sgn_q ? -prod_d : prod_d;
    div_val = op_q[1] ? prod_d[2*XLEN-1:XLEN] : prod_d[XLEN-1:0];
    fin     = op_q[2] ? (sgn_q ? -div_val : div_val) :
              (op_q[1:0] == 2'b00) ? prod_n[XLEN-1:0] : prod_n[2*XLEN-1:XLEN];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      sgn_q   <= 1'b0;
      opb_q   <= '0;
      res_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid & ~kill) begin
          op_q   <= in_funct3;
          sgn_q  <= (in_funct3[2] & in_funct3[1]) ? a_neg : a_neg ^ b_neg;
          opb_q  <= is_div ? mag_b : mag_a;
          prod_q <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
          if (is_div & (b_zero | ovf)) begin
            res_q   <= sp_res;
            state_q <= DONE;
          end else begin
            cnt_q   <= CNT_W'(XLEN);
            state_q <= CALC;
          end
        end
        CALC: if (kill) state_q <= IDLE;
        else begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_q   <= fin;
            state_q <= DONE;
          end
        end
        DONE: if (kill | out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M execution unit. Sits beside the single-cycle ALU in the execute stage and takes over when the decoder sees an R-type op with funct7 = 0000001.
- Generalises ALU op selection to the M extension: width is parametrised, the unit is multi-cycle, and it talks to the pipeline through valid/ready handshakes with a kill input.
- The pipeline stalls on in_ready/out_valid.

Parameters:
XLEN, 32, operand/result width in bits (>= 4, even)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  unit can accept (high only in IDLE, low while reset asserted)
in_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
in_a  input  XLEN  rs1 value
in_b  input  XLEN  rs2 value
kill  input  1  pipeline flush; abandons any operation
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_result  output  XLEN  result

Behaviour:
- Reset: state IDLE, out_valid = 0, out_result = 0, counter = 0, all datapath regs = 0. Reset takes priority over kill and handshakes.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - An accept happens on an edge with in_valid & ~kill. At accept, latch funct3, operand magnitudes and result sign.
  - Accept goes to CALC with counter = XLEN, except for special-case division, which goes straight to DONE.
- CALC:
  - One radix-2 step per cycle; counter decrements.
  - When counter reaches 1 at an edge, go to DONE with out_result registered.
  - Normal latency: out_valid is first high XLEN+1 cycles after the accept edge.
- DONE:
  - out_valid = 1.
  - out_result is held stable until out_valid & out_ready, then IDLE.
  - The next request is accepted no earlier than the cycle after the output handshake; there is no same-cycle turnaround.
- kill:
  - In CALC or DONE: next state IDLE, out_valid = 0 next cycle, no result delivered.
  - In IDLE: blocks the accept.
- Multiply:
  - Shift-add on unsigned magnitudes into a 2*XLEN product, then two's-complement negate if the sign flag is set.
  - Sign flag: MUL/MULH set it on a[XLEN-1]^b[XLEN-1]; MULHSU on a[XLEN-1] only; MULHU never.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes (unsigned ops use raw operands).
  - DIV quotient is negated if the operand signs differ.
  - REM remainder takes the dividend's sign.
- Special cases (no iteration, DONE one cycle after accept):
  - b == 0: DIV/DIVU -> all ones; REM/REMU -> in_a.
  - Signed overflow (DIV/REM with a = most negative, b = all ones): DIV -> in_a; REM -> 0.
- Zero operands for multiply are not special-cased; they take the full latency.
- Simultaneous events:
  - out_ready and kill together in DONE: kill wins, and the result is treated as not delivered.
  - in_valid is ignored whenever in_ready = 0.
- No X on outputs: out_result stays 0 until the first result and then holds the last result until the next DONE.

Test Plan:
- Reset, then MUL 7 × 0xFFFFFFFD (XLEN=32) -> out_valid first high 33 cycles after accept, out_result 0xFFFFFFEB; in_ready low throughout.
- Upper-half multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- Signed division, a = 0xFFFFFFF9, b = 2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Specials, each with out_valid one cycle after accept:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Backpressure: hold out_ready low 5 cycles in DONE -> out_valid/out_result stable, in_ready 0, in_valid ignored. Raise out_ready -> IDLE next cycle, and a back-to-back request is then accepted.
- Abort paths:
  - kill on cycle 10 of CALC -> IDLE next cycle, in_ready 1, no out_valid pulse.
  - Reset asserted mid-CALC -> all outputs at reset values next cycle.
  - kill with out_ready in DONE -> out_valid low next cycle.
